// File: rtl/uc_multiciclo.sv
// Multicycle control unit for the MIPS datapath.
// Sequences fetch/decode/execute/memory/writeback, waits on mem_ready with a
// timeout watchdog, traps on illegal opcodes and counts retired instructions.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   instrucao         opcode field from IR (sampled only in DECODE)
//   mem_ready         memory completed current access this cycle
//   pc_write .. alu_src_a, alu_src_b, alu_op, pc_source   datapath controls
//   state             current state (debug), encoding:
//                     0 IDLE 1 FETCH 2 DECODE 3 MEMADR 4 MEMRD 5 MEMWB 6 MEMWR
//                     7 EXEC 8 ALUWB 9 BRANCH 10 JUMP 11 TRAP
//   illegal, bus_error  sticky trap flags
//   instr_count       retired instructions, wraps
module uc_multiciclo #(
  parameter int unsigned OPCODE_W    = 6,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32,
  parameter logic [OPCODE_W-1:0] OP_R   = 6'b000000,
  parameter logic [OPCODE_W-1:0] OP_I   = 6'b000001,
  parameter logic [OPCODE_W-1:0] OP_LW  = 6'b100010,
  parameter logic [OPCODE_W-1:0] OP_SW  = 6'b101010,
  parameter logic [OPCODE_W-1:0] OP_BEQ = 6'b000100,
  parameter logic [OPCODE_W-1:0] OP_BNE = 6'b000110,
  parameter logic [OPCODE_W-1:0] OP_J   = 6'b010100
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] instrucao,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                branch_ne,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                mem_to_reg,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic [1:0]          pc_source,
  output logic [3:0]          state,
  output logic                illegal,
  output logic                bus_error,
  output logic [CNT_W-1:0]    instr_count
);

  typedef enum logic [3:0] {
    StIdle   = 4'd0,
    StFetch  = 4'd1,
    StDecode = 4'd2,
    StMemAdr = 4'd3,
    StMemRd  = 4'd4,
    StMemWb  = 4'd5,
    StMemWr  = 4'd6,
    StExec   = 4'd7,
    StAluWb  = 4'd8,
    StBranch = 4'd9,
    StJump   = 4'd10,
    StTrap   = 4'd11
  } state_e;

  localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);

  state_e              state_q, state_d;
  logic [OPCODE_W-1:0] op_q, op_d;
  logic [WAIT_W-1:0]   wait_q, wait_d, wait_inc;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                illegal_q, illegal_d, bus_error_q, bus_error_d;
  logic                timeout, retire, is_wait_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      op_q        <= '0;
      wait_q      <= '0;
      count_q     <= '0;
      illegal_q   <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      wait_q      <= wait_d;
      count_q     <= count_d;
      illegal_q   <= illegal_d;
      bus_error_q <= bus_error_d;
    end
  end

  assign wait_inc = wait_q + 1'b1;
  // Trap on the cycle the counter would reach the limit; a ready in that cycle wins.
  assign timeout  = (MEM_TIMEOUT != 0) && !mem_ready && (wait_inc == TIMEOUT_V);
  assign is_wait_state = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    illegal_d     = illegal_q;
    bus_error_d   = bus_error_q;
    retire        = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;

    unique case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) begin
          state_d = StDecode;
        end else if (timeout) begin
          state_d     = StTrap;
          bus_error_d = 1'b1;
        end
      end
      StDecode: begin
        alu_src_b = 2'b11;
        op_d      = instrucao;
        if (instrucao == OP_R || instrucao == OP_I) begin
          state_d = StExec;
        end else if (instrucao == OP_LW || instrucao == OP_SW) begin
          state_d = StMemAdr;
        end else if (instrucao == OP_BEQ || instrucao == OP_BNE) begin
          state_d = StBranch;
        end else if (instrucao == OP_J) begin
          state_d = StJump;
        end else begin
          state_d   = StTrap;
          illegal_d = 1'b1;
        end
      end
      StMemAdr: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (op_q == OP_LW) ? StMemRd : StMemWr;
      end
      StMemRd: begin
        i_or_d   = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) begin
          state_d = StMemWb;
        end else if (timeout) begin
          state_d     = StTrap;
          bus_error_d = 1'b1;
        end
      end
      StMemWb: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        state_d    = StFetch;
        retire     = 1'b1;
      end
      StMemWr: begin
        i_or_d    = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) begin
          state_d = StFetch;
          retire  = 1'b1;
        end else if (timeout) begin
          state_d     = StTrap;
          bus_error_d = 1'b1;
        end
      end
      StExec: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        alu_src_b = (op_q == OP_R) ? 2'b00 : 2'b10;
        state_d   = StAluWb;
      end
      StAluWb: begin
        reg_write = 1'b1;
        reg_dst   = (op_q == OP_R);
        state_d   = StFetch;
        retire    = 1'b1;
      end
      StBranch: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        branch_ne     = (op_q == OP_BNE);
        state_d       = StFetch;
        retire        = 1'b1;
      end
      StJump: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        state_d   = StFetch;
        retire    = 1'b1;
      end
      StTrap: state_d = StTrap;
      default: state_d = StIdle;
    endcase

    // Clear on any state change so each wait state starts a fresh budget.
    if (state_d != state_q) begin
      wait_d = '0;
    end else if (is_wait_state && !mem_ready) begin
      wait_d = wait_inc;
    end else begin
      wait_d = wait_q;
    end

    count_d = retire ? (count_q + 1'b1) : count_q;
  end

  assign state       = state_q;
  assign illegal     = illegal_q;
  assign bus_error   = bus_error_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_uc_multiciclo.sv
// Self-checking bench for uc_multiciclo (MEM_TIMEOUT=4, CNT_W=8).
// Per-cycle stimulus and expected outputs are queued, then replayed and checked.
module tb_uc_multiciclo;

  localparam int unsigned CW = 8;

  localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_MEMADR = 4'd3,
                         S_MEMRD = 4'd4, S_MEMWB = 4'd5, S_MEMWR = 4'd6, S_EXEC = 4'd7,
                         S_ALUWB = 4'd8, S_BRANCH = 4'd9, S_JUMP = 4'd10, S_TRAP = 4'd11;

  localparam logic [5:0] OR = 6'b000000, OI = 6'b000001, OLW = 6'b100010, OSW = 6'b101010,
                         OBEQ = 6'b000100, OBNE = 6'b000110, OJ = 6'b010100, OBAD = 6'b111111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [5:0] instrucao = '0;
  logic mem_ready = 1'b1;
  logic pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write, ir_write;
  logic mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;
  logic illegal, bus_error;
  logic [CW-1:0] instr_count;

  uc_multiciclo #(.MEM_TIMEOUT(4), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .instrucao(instrucao), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
    .state(state), .illegal(illegal), .bus_error(bus_error), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [5:0] op; logic rdy; } stim_t;
  typedef struct {
    logic [3:0] st; logic [16:0] ctl; logic [CW-1:0] cnt; logic ill; logic berr;
  } exp_t;

  stim_t stim_q[$];
  exp_t  exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  logic [16:0] obs_ctl;
  assign obs_ctl = {pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write, ir_write,
                    mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

  function automatic logic [16:0] c(input logic pcw, pcwc, bne, iord, mr, mw, irw, m2r, rd, rw,
                                    sa, input logic [1:0] sb, aop, ps);
    return {pcw, pcwc, bne, iord, mr, mw, irw, m2r, rd, rw, sa, sb, aop, ps};
  endfunction

  // Expected control vectors, written directly from the state table.
  function automatic logic [16:0] v_fetch(input logic rdy);
    return c(rdy, 0, 0, 0, 1, 0, rdy, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00);
  endfunction
  function automatic logic [16:0] v_decode();
    return c(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00);
  endfunction
  function automatic logic [16:0] v_memadr();
    return c(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00);
  endfunction
  function automatic logic [16:0] v_memrd();
    return c(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
  endfunction
  function automatic logic [16:0] v_memwb();
    return c(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00);
  endfunction
  function automatic logic [16:0] v_memwr();
    return c(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
  endfunction
  function automatic logic [16:0] v_exec(input logic is_r);
    return c(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, is_r ? 2'b00 : 2'b10, 2'b10, 2'b00);
  endfunction
  function automatic logic [16:0] v_aluwb(input logic is_r);
    return c(0, 0, 0, 0, 0, 0, 0, 0, is_r, 1, 0, 2'b00, 2'b00, 2'b00);
  endfunction
  function automatic logic [16:0] v_branch(input logic ne);
    return c(0, 1, ne, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01);
  endfunction
  function automatic logic [16:0] v_jump();
    return c(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10);
  endfunction

  // Opcode outside DECODE is random: the DUT must ignore it.
  function automatic logic [5:0] rnd_op();
    return 6'($urandom);
  endfunction

  task automatic push(input logic [5:0] op, input logic rdy, input logic [3:0] st,
                      input logic [16:0] ctl, input logic [CW-1:0] cnt, input logic ill,
                      input logic berr);
    stim_t s;
    exp_t e;
    s.op = op; s.rdy = rdy;
    e.st = st; e.ctl = ctl; e.cnt = cnt; e.ill = ill; e.berr = berr;
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  // Apply next stimulus (called just after a rising edge), pop the matching expectation.
  task automatic advance(output exp_t e);
    stim_t s;
    s = stim_q.pop_front();
    instrucao = s.op;
    mem_ready = s.rdy;
    @(negedge clk);
    e = exp_q.pop_front();
    vectors++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    do_reset();
    push(rnd_op(), 1, S_IDLE, '0, 0, 0, 0);
    push(rnd_op(), 1, S_FETCH, v_fetch(1), 0, 0, 0);
    while (exp_q.size() > 0) begin
      advance(e);
      if ({state, obs_ctl, instr_count, illegal, bus_error} !== {e.st, e.ctl, e.cnt, e.ill, e.berr})
        begin
        miscompares++;
        $display("FAIL reset vec%0d: got st=%0d ctl=%h cnt=%0d ill=%b berr=%b want st=%0d ctl=%h cnt=%0d ill=%b berr=%b",
                 vectors, state, obs_ctl, instr_count, illegal, bus_error,
                 e.st, e.ctl, e.cnt, e.ill, e.berr);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_alu();
    exp_t e;
    do_reset();
    push(rnd_op(), 1, S_IDLE, '0, 0, 0, 0);
    push(rnd_op(), 1, S_FETCH, v_fetch(1), 0, 0, 0);
    push(OR, 1, S_DECODE, v_decode(), 0, 0, 0);
    push(rnd_op(), 1, S_EXEC, v_exec(1), 0, 0, 0);
    push(rnd_op(), 1, S_ALUWB, v_aluwb(1), 0, 0, 0);
    push(rnd_op(), 0, S_FETCH, v_fetch(0), 1, 0, 0);
    push(rnd_op(), 1, S_FETCH, v_fetch(1), 1, 0, 0);
    push(OI, 1, S_DECODE, v_decode(), 1, 0, 0);
    push(rnd_op(), 1, S_EXEC, v_exec(0), 1, 0, 0);
    push(rnd_op(), 1, S_ALUWB, v_aluwb(0), 1, 0, 0);
    push(rnd_op(), 1, S_FETCH, v_fetch(1), 2, 0, 0);
    while (exp_q.size() > 0) begin
      advance(e);
      if ({state, obs_ctl, instr_count, illegal, bus_error} !== {e.st, e.ctl, e.cnt, e.ill, e.berr})
        begin
        miscompares++;
        $display("FAIL alu vec%0d: got st=%0d ctl=%h cnt=%0d ill=%b berr=%b want st=%0d ctl=%h cnt=%0d ill=%b berr=%b",
                 vectors, state, obs_ctl, instr_count, illegal, bus_error,
                 e.st, e.ctl, e.cnt, e.ill, e.berr);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_load_wait();
    exp_t e;
    do_reset();
    push(rnd_op(), 1, S_IDLE, '0, 0, 0, 0);
    push(rnd_op(), 1, S_FETCH, v_fetch(1), 0, 0, 0);
    push(OLW, 1, S_DECODE, v_decode(), 0, 0, 0);
    push(OBAD, 1, S_MEMADR, v_memadr(), 0, 0, 0);
    for (int i = 0; i < 3; i++) push(OSW, 0, S_MEMRD, v_memrd(), 0, 0, 0);
    push(rnd_op(), 1, S_MEMRD, v_memrd(), 0, 0, 0);
    push(rnd_op(), 1, S_MEMWB, v_memwb(), 0, 0, 0);
    push(rnd_op(), 1, S_FETCH, v_fetch(1), 1, 0, 0);
    while (exp_q.size() > 0) begin
      advance(e);
      if ({state, obs_ctl, instr_count, illegal, bus_error} !== {e.st, e.ctl, e.cnt, e.ill, e.berr})
        begin
        miscompares++;
        $display("FAIL load_wait vec%0d: got st=%0d ctl=%h cnt=%0d ill=%b berr=%b want st=%0d ctl=%h cnt=%0d ill=%b berr=%b",
                 vectors, state, obs_ctl, instr_count, illegal, bus_error,
                 e.st, e.ctl, e.cnt, e.ill, e.berr);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_store_timeout();
    exp_t e;
    do_reset();
    push(rnd_op(), 1, S_IDLE, '0, 0, 0, 0);
    push(rnd_op(), 1, S_FETCH, v_fetch(1), 0, 0, 0);
    push(OSW, 1, S_DECODE, v_decode(), 0, 0, 0);
    push(rnd_op(), 1, S_MEMADR, v_memadr(), 0, 0, 0);
    // Ready arrives on the 4th wait cycle: ready wins over the watchdog.
    for (int i = 0; i < 3; i++) push(rnd_op(), 0, S_MEMWR, v_memwr(), 0, 0, 0);
    push(rnd_op(), 1, S_MEMWR, v_memwr(), 0, 0, 0);
    push(rnd_op(), 1, S_FETCH, v_fetch(1), 1, 0, 0);
    push(OSW, 1, S_DECODE, v_decode(), 1, 0, 0);
    push(rnd_op(), 1, S_MEMADR, v_memadr(), 1, 0, 0);
    for (int i = 0; i < 4; i++) push(rnd_op(), 0, S_MEMWR, v_memwr(), 1, 0, 0);
    push(rnd_op(), 0, S_TRAP, '0, 1, 0, 1);
    push(rnd_op(), 1, S_TRAP, '0, 1, 0, 1);
    push(OJ, 1, S_TRAP, '0, 1, 0, 1);
    while (exp_q.size() > 0) begin
      advance(e);
      if ({state, obs_ctl, instr_count, illegal, bus_error} !== {e.st, e.ctl, e.cnt, e.ill, e.berr})
        begin
        miscompares++;
        $display("FAIL store_timeout vec%0d: got st=%0d ctl=%h cnt=%0d ill=%b berr=%b want st=%0d ctl=%h cnt=%0d ill=%b berr=%b",
                 vectors, state, obs_ctl, instr_count, illegal, bus_error,
                 e.st, e.ctl, e.cnt, e.ill, e.berr);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_branch();
    exp_t e;
    do_reset();
    push(rnd_op(), 1, S_IDLE, '0, 0, 0, 0);
    push(rnd_op(), 1, S_FETCH, v_fetch(1), 0, 0, 0);
    push(OBNE, 1, S_DECODE, v_decode(), 0, 0, 0);
    push(rnd_op(), 1, S_BRANCH, v_branch(1), 0, 0, 0);
    push(rnd_op(), 1, S_FETCH, v_fetch(1), 1, 0, 0);
    push(OBEQ, 1, S_DECODE, v_decode(), 1, 0, 0);
    push(OBNE, 1, S_BRANCH, v_branch(0), 1, 0, 0);
    push(rnd_op(), 1, S_FETCH, v_fetch(1), 2, 0, 0);
    while (exp_q.size() > 0) begin
      advance(e);
      if ({state, obs_ctl, instr_count, illegal, bus_error} !== {e.st, e.ctl, e.cnt, e.ill, e.berr})
        begin
        miscompares++;
        $display("FAIL branch vec%0d: got st=%0d ctl=%h cnt=%0d ill=%b berr=%b want st=%0d ctl=%h cnt=%0d ill=%b berr=%b",
                 vectors, state, obs_ctl, instr_count, illegal, bus_error,
                 e.st, e.ctl, e.cnt, e.ill, e.berr);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_illegal();
    exp_t e;
    do_reset();
    push(rnd_op(), 1, S_IDLE, '0, 0, 0, 0);
    push(rnd_op(), 1, S_FETCH, v_fetch(1), 0, 0, 0);
    push(OBAD, 1, S_DECODE, v_decode(), 0, 0, 0);
    for (int i = 0; i < 10; i++) push(OR, 1, S_TRAP, '0, 0, 1, 0);
    while (exp_q.size() > 0) begin
      advance(e);
      if ({state, obs_ctl, instr_count, illegal, bus_error} !== {e.st, e.ctl, e.cnt, e.ill, e.berr})
        begin
        miscompares++;
        $display("FAIL illegal vec%0d: got st=%0d ctl=%h cnt=%0d ill=%b berr=%b want st=%0d ctl=%h cnt=%0d ill=%b berr=%b",
                 vectors, state, obs_ctl, instr_count, illegal, bus_error,
                 e.st, e.ctl, e.cnt, e.ill, e.berr);
      end
      @(posedge clk);
      #1;
    end
    do_reset();
    push(rnd_op(), 1, S_IDLE, '0, 0, 0, 0);
    push(rnd_op(), 1, S_FETCH, v_fetch(1), 0, 0, 0);
    while (exp_q.size() > 0) begin
      advance(e);
      if ({state, obs_ctl, instr_count, illegal, bus_error} !== {e.st, e.ctl, e.cnt, e.ill, e.berr})
        begin
        miscompares++;
        $display("FAIL trap_exit vec%0d: got st=%0d ctl=%h cnt=%0d ill=%b berr=%b want st=%0d ctl=%h cnt=%0d ill=%b berr=%b",
                 vectors, state, obs_ctl, instr_count, illegal, bus_error,
                 e.st, e.ctl, e.cnt, e.ill, e.berr);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    do_reset();
    push(rnd_op(), 1, S_IDLE, '0, 0, 0, 0);
    push(rnd_op(), 1, S_FETCH, v_fetch(1), 0, 0, 0);
    push(OSW, 1, S_DECODE, v_decode(), 0, 0, 0);
    push(rnd_op(), 1, S_MEMADR, v_memadr(), 0, 0, 0);
    push(rnd_op(), 0, S_MEMWR, v_memwr(), 0, 0, 0);
    while (exp_q.size() > 0) begin
      advance(e);
      if ({state, obs_ctl, instr_count, illegal, bus_error} !== {e.st, e.ctl, e.cnt, e.ill, e.berr})
        begin
        miscompares++;
        $display("FAIL reset_mid vec%0d: got st=%0d ctl=%h cnt=%0d ill=%b berr=%b want st=%0d ctl=%h cnt=%0d ill=%b berr=%b",
                 vectors, state, obs_ctl, instr_count, illegal, bus_error,
                 e.st, e.ctl, e.cnt, e.ill, e.berr);
      end
      @(posedge clk);
      #1;
    end
    // Still in MEMWR waiting; assert reset between edges, expect immediate IDLE.
    rst_n = 1'b0;
    #2;
    vectors++;
    if ({state, obs_ctl} !== {S_IDLE, 17'h0}) begin
      miscompares++;
      $display("FAIL async_reset: got st=%0d ctl=%h want st=%0d ctl=%h", state, obs_ctl, S_IDLE,
               17'h0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_count_wrap();
    exp_t e;
    do_reset();
    push(rnd_op(), 1, S_IDLE, '0, 0, 0, 0);
    for (int k = 0; k < 256; k++) begin
      push(rnd_op(), 1, S_FETCH, v_fetch(1), CW'(k), 0, 0);
      push(OJ, 1, S_DECODE, v_decode(), CW'(k), 0, 0);
      push(rnd_op(), 1, S_JUMP, v_jump(), CW'(k), 0, 0);
    end
    push(rnd_op(), 1, S_FETCH, v_fetch(1), '0, 0, 0);
    while (exp_q.size() > 0) begin
      advance(e);
      if ({state, obs_ctl, instr_count, illegal, bus_error} !== {e.st, e.ctl, e.cnt, e.ill, e.berr})
        begin
        miscompares++;
        $display("FAIL count_wrap vec%0d: got st=%0d ctl=%h cnt=%0d ill=%b berr=%b want st=%0d ctl=%h cnt=%0d ill=%b berr=%b",
                 vectors, state, obs_ctl, instr_count, illegal, bus_error,
                 e.st, e.ctl, e.cnt, e.ill, e.berr);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_alu();
    test_load_wait();
    test_store_timeout();
    test_branch();
    test_illegal();
    test_reset_mid();
    test_count_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
